hdmi_tmds_rx: RTL and testbench

Single-lane TMDS receiver for the HDMI path. It deserializes one TMDS data lane sampled on the bit clock and finds the 10-bit word boundary from the control tokens sent during blanking. It then decodes each word into an 8-bit pixel value or a 2-bit control code. One instance sits behind each of the three lane inputs and is the receive-side counterpart of the TMDS serializer.

---
 rtl/hdmi_tmds_rx.sv | 126 ++++++++++++
 tb/tb_hdmi_tmds_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_tmds_rx.sv
// Single-lane TMDS receiver: bit-serial deserializer, word alignment on
// blanking control tokens, and TMDS data/control decode.
module hdmi_tmds_rx #(
  parameter int LOCK_COUNT    = 4,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input  logic       hdmi_tdms_clock,
  input  logic       hdmi_tdms_resetn,
  input  logic       hdmi_rx_d,
  output logic       word_valid,
  output logic [9:0] word_raw,
  output logic [7:0] word_data,
  output logic [1:0] word_ctrl,
  output logic       word_is_ctrl,
  output logic       locked,
  output logic       lock_lost
);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam logic [3:0]  LC = 4'(LOCK_COUNT);
  localparam logic [15:0] TT = 16'(TOKEN_TIMEOUT);

  state_t      state;
  logic [9:0]  sr;
  logic [3:0]  ph;
  logic [3:0]  cnt;
  logic [15:0] tmo;
  logic [15:0] tmo_nxt;
  logic        tok_hit;
  logic [1:0]  tok_code;
  logic        bnd;

  always_comb begin
    tok_hit  = 1'b1;
    tok_code = 2'd0;
    case (sr)
      10'b1101010100: tok_code = 2'd0;
      10'b0010101011: tok_code = 2'd1;
      10'b0101010100: tok_code = 2'd2;
      10'b1010101011: tok_code = 2'd3;
      default:        tok_hit  = 1'b0;
    endcase
  end

  assign bnd = (ph == 4'd9);
  // Token check first, then saturating increment; the exit test uses this value.
  assign tmo_nxt = tok_hit ? 16'd0 : ((tmo >= TT) ? tmo : tmo + 16'd1);

  function automatic logic [7:0] tmds_dec(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] o;
    d    = q[9] ? ~q[7:0] : q[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++)
      o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  always_ff @(posedge hdmi_tdms_clock or negedge hdmi_tdms_resetn) begin
    if (!hdmi_tdms_resetn) begin
      state        <= SEARCH;
      sr           <= '0;
      ph           <= '0;
      cnt          <= '0;
      tmo          <= '0;
      word_valid   <= 1'b0;
      word_raw     <= '0;
      word_data    <= '0;
      word_ctrl    <= '0;
      word_is_ctrl <= 1'b1;
      locked       <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      sr         <= {hdmi_rx_d, sr[9:1]};
      ph         <= bnd ? 4'd0 : ph + 4'd1;
      word_valid <= 1'b0;
      lock_lost  <= 1'b0;
      case (state)
        SEARCH: if (tok_hit) begin
          // The token just completed, so the next boundary is 10 bits away.
          ph  <= 4'd0;
          cnt <= 4'd1;
          tmo <= '0;
          if (LC == 4'd1) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end else begin
            state <= VERIFY;
          end
        end
        VERIFY: if (bnd) begin
          if (tok_hit) begin
            cnt <= cnt + 4'd1;
            if (cnt + 4'd1 == LC) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end else begin
            state <= SEARCH;
            cnt   <= '0;
          end
        end
        LOCKED: if (bnd) begin
          word_valid   <= 1'b1;
          word_raw     <= sr;
          word_is_ctrl <= tok_hit;
          if (tok_hit) begin
            word_ctrl <= tok_code;
            word_data <= '0;
          end else begin
            word_data <= tmds_dec(sr);
          end
          tmo <= tmo_nxt;
          if (tmo_nxt >= TT) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            lock_lost <= 1'b1;
            cnt       <= '0;
            tmo       <= '0;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end
endmodule

// File: tb/tb_hdmi_tmds_rx.sv
// Bench for hdmi_tmds_rx: random and directed bit streams checked every cycle
// against a word-level reference, plus directed lock/timeout/reset timing checks.
module tb_hdmi_tmds_rx;
  localparam int LC = 4;
  localparam int TT = 16;
  localparam logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011,
                                     10'b0101010100, 10'b1010101011};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d;
  logic       word_valid;
  logic [9:0] word_raw;
  logic [7:0] word_data;
  logic [1:0] word_ctrl;
  logic       word_is_ctrl;
  logic       locked;
  logic       lock_lost;

  hdmi_tmds_rx #(.LOCK_COUNT(LC), .TOKEN_TIMEOUT(TT)) dut (
    .hdmi_tdms_clock (clk),
    .hdmi_tdms_resetn(rst_n),
    .hdmi_rx_d       (d),
    .word_valid      (word_valid),
    .word_raw        (word_raw),
    .word_data       (word_data),
    .word_ctrl       (word_ctrl),
    .word_is_ctrl    (word_is_ctrl),
    .locked          (locked),
    .lock_lost       (lock_lost)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ecnt  = 0;
  bit lk_h [0:2047];
  bit vl_h [0:2047];
  bit ll_h [0:2047];
  logic [7:0] cap_data [$];
  logic [1:0] cap_ctrl [$];
  logic       cap_isc  [$];

  // Reference: alignment anchored at the edge where a token was first seen.
  int         m_state, m_e0, m_cnt, m_tmo;
  logic [9:0] m_sr;
  logic       e_valid, e_isc, e_locked, e_lost;
  logic [9:0] e_raw;
  logic [7:0] e_data;
  logic [1:0] e_ctrl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int tok_of(input logic [9:0] w);
    for (int i = 0; i < 4; i++) if (w == TOK[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] ref_dec(input logic [9:0] q);
    logic [7:0] dd;
    dd = q[7:0] ^ {8{q[9]}};
    return dd ^ {dd[6:0], 1'b0} ^ (q[8] ? 8'h00 : 8'hFE);
  endfunction

  function automatic logic [9:0] rnd_word();
    logic [9:0] w;
    w = 10'($urandom);
    while (tok_of(w) >= 0) w = 10'($urandom);
    return w;
  endfunction

  task automatic model_reset();
    m_state = 0; m_e0 = 0; m_cnt = 0; m_tmo = 0; m_sr = '0;
    e_valid = 0; e_raw = '0; e_data = '0; e_ctrl = '0; e_isc = 1;
    e_locked = 0; e_lost = 0; ecnt = 0;
  endtask

  task automatic model_edge(input logic b);
    int  tk;
    bit  bnd;
    tk  = tok_of(m_sr);
    bnd = (m_state != 0) && (ecnt > m_e0) && ((ecnt - m_e0) % 10 == 0);
    e_valid = 0;
    e_lost  = 0;
    if (m_state == 0) begin
      if (tk >= 0) begin
        m_e0 = ecnt; m_cnt = 1; m_tmo = 0;
        if (LC == 1) begin m_state = 2; e_locked = 1; end
        else m_state = 1;
      end
    end else if (m_state == 1) begin
      if (bnd) begin
        if (tk >= 0) begin
          m_cnt++;
          if (m_cnt == LC) begin m_state = 2; e_locked = 1; end
        end else begin
          m_state = 0; m_cnt = 0;
        end
      end
    end else if (bnd) begin
      e_valid = 1;
      e_raw   = m_sr;
      if (tk >= 0) begin
        e_isc = 1; e_ctrl = 2'(tk); e_data = '0; m_tmo = 0;
      end else begin
        e_isc = 0; e_data = ref_dec(m_sr);
        if (m_tmo < TT) m_tmo++;
      end
      if (m_tmo >= TT) begin
        m_state = 0; e_locked = 0; e_lost = 1; m_tmo = 0; m_cnt = 0;
      end
    end
    m_sr = {b, m_sr[9:1]};
  endtask

  task automatic step(input logic b);
    d = b;
    @(posedge clk);
    ecnt++;
    model_edge(b);
    #1;
    if (ecnt < 2048) begin
      lk_h[ecnt] = locked; vl_h[ecnt] = word_valid; ll_h[ecnt] = lock_lost;
    end
    if (word_valid === 1'b1) begin
      cap_data.push_back(word_data); cap_ctrl.push_back(word_ctrl);
      cap_isc.push_back(word_is_ctrl);
    end
    chk($sformatf("valid@%0d", ecnt), 32'(word_valid), 32'(e_valid));
    chk($sformatf("locked@%0d", ecnt), 32'(locked), 32'(e_locked));
    chk($sformatf("lost@%0d", ecnt), 32'(lock_lost), 32'(e_lost));
    chk($sformatf("raw@%0d", ecnt), 32'(word_raw), 32'(e_raw));
    chk($sformatf("data@%0d", ecnt), 32'(word_data), 32'(e_data));
    chk($sformatf("ctrl@%0d", ecnt), 32'(word_ctrl), 32'(e_ctrl));
    chk($sformatf("isctrl@%0d", ecnt), 32'(word_is_ctrl), 32'(e_isc));
  endtask

  task automatic send(input logic [9:0] w);
    for (int i = 0; i < 10; i++) step(w[i]);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"},  32'(word_valid),   32'd0);
    chk({tag, "_raw"},    32'(word_raw),     32'd0);
    chk({tag, "_data"},   32'(word_data),    32'd0);
    chk({tag, "_ctrl"},   32'(word_ctrl),    32'd0);
    chk({tag, "_isctrl"}, 32'(word_is_ctrl), 32'd1);
    chk({tag, "_locked"}, 32'(locked),       32'd0);
    chk({tag, "_lost"},   32'(lock_lost),    32'd0);
  endtask

  task automatic do_reset();
    d = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    model_reset();
  endtask

  function automatic int sum_hist(input int kind, input int lo, input int hi);
    int n = 0;
    for (int e = lo; e <= hi; e++)
      n += (kind == 0) ? int'(lk_h[e]) : (kind == 1) ? int'(vl_h[e]) : int'(ll_h[e]);
    return n;
  endfunction

  initial begin
    int s, s1;
    rst_n = 1'b1; d = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("por");
    model_reset();
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;

    // Broken verify: two tokens, a data word, then a fresh run of four.
    send(TOK[0]); send(TOK[0]); send(10'b0100000000);
    for (int i = 0; i < 4; i++) send(TOK[0]);
    send(rnd_word());
    chk("bv_nolock_early", 32'(sum_hist(0, 1, 70)), 32'd0);
    chk("bv_lock_edge", 32'(lk_h[71]), 32'd1);

    // Lock at bit offset 3.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'($urandom));
    for (int i = 0; i < 6; i++) send(TOK[0]);
    chk("lk_pre", 32'(lk_h[43]), 32'd0);
    chk("lk_rise", 32'(lk_h[44]), 32'd1);
    chk("lk_no_early_word", 32'(sum_hist(1, 1, 53)), 32'd0);
    cap_data.delete(); cap_ctrl.delete(); cap_isc.delete();

    // Decode: three data words and all four tokens.
    send(10'b0100000000); send(10'b1011111111); send(10'b0111111111);
    for (int i = 0; i < 4; i++) send(TOK[i]);
    chk("lk_word1", 32'(vl_h[54]), 32'd1);
    chk("lk_word2", 32'(vl_h[64]), 32'd1);
    chk("lk_gap", 32'(sum_hist(1, 55, 63)), 32'd0);

    // Timeout window: the 16th word is a token, so lock holds.
    s1 = ecnt;
    for (int i = 0; i < 15; i++) send(rnd_word());
    send(TOK[0]);
    s = ecnt;
    // Captured order: token, 0100000000, 1011111111, 0111111111, four tokens.
    chk("cap_tok_isc", 32'(cap_isc[0]), 32'd1);
    chk("dec_0100000000", 32'(cap_data[1]), 32'h00);
    chk("dec_isc", 32'(cap_isc[1]), 32'd0);
    // q[8]=0 turns the xor chain into xnor, giving FE for this word.
    chk("dec_1011111111", 32'(cap_data[2]), 32'hFE);
    chk("dec_0111111111", 32'(cap_data[3]), 32'h01);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tok_ctrl%0d", i), 32'(cap_ctrl[4+i]), 32'(i));
      chk($sformatf("tok_data%0d", i), 32'(cap_data[4+i]), 32'd0);
    end

    // Timeout: 16 data words drop lock.
    for (int i = 0; i < 16; i++) send(rnd_word());
    send(rnd_word());
    chk("tok16_keep", 32'(sum_hist(2, s1 + 1, s + 1)), 32'd0);
    chk("tok16_locked", 32'(lk_h[s + 1]), 32'd1);
    chk("to_lost_pre", 32'(ll_h[s + 160]), 32'd0);
    chk("to_lost", 32'(ll_h[s + 161]), 32'd1);
    chk("to_lost_post", 32'(ll_h[s + 162]), 32'd0);
    chk("to_word16", 32'(vl_h[s + 161]), 32'd1);
    chk("to_lk_pre", 32'(lk_h[s + 160]), 32'd1);
    chk("to_lk_fall", 32'(lk_h[s + 161]), 32'd0);

    // Relock, then asynchronous reset mid-word.
    for (int i = 0; i < 20; i++) step(1'b0);
    for (int i = 0; i < 6; i++) send(TOK[0]);
    for (int i = 0; i < 3; i++) step(1'($urandom));
    chk("pre_rst_locked", 32'(locked), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) send(TOK[0]);
    send(rnd_word());
    chk("relock_none_early", 32'(sum_hist(0, 1, 40)), 32'd0);
    chk("relock_edge", 32'(lk_h[41]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
